branch_predict_ctrl: RTL
========================

# branch_predict_ctrl

Branch prediction and resolution controller for the pipelined RISC-V core. It holds a bimodal branch history table (BHT) of 2-bit saturating counters that the fetch stage reads for a taken/not-taken prediction. In execute it compares the prediction against the taken result produced by `BranchLogic` (`LogOut`). On a mismatch it issues the PC redirect and pipeline flushes, runs a one-cycle recovery state, updates the BHT and keeps branch/mispredict statistics.

## Interface
- `BHT_ENTRIES`, 64, number of BHT entries; power of two, 4..1024; index width `IW = log2(BHT_ENTRIES)`.
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `PCF` input 32 — fetch PC; BHT read index `PCF[IW+1:2]`.
- `PredTakenF` output 1 — MSB of the indexed counter; combinational.
- `BranchE` input 1 — a conditional branch occupies EX this cycle.
- `StallE` input 1 — EX is stalled; the EX instruction is not retired this cycle.
- `PCE` input 32 — PC of the EX instruction; BHT update index `PCE[IW+1:2]`.
- `PredTakenE` input 1 — prediction made for this instruction, carried from fetch.
- `CondTakenE` input 1 — actual outcome from `BranchLogic.LogOut`.
- `PCTargetE` input 32 — branch target.
- `PCPlus4E` input 32 — fall-through PC.
- `RedirectE` output 1 — fetch must load `RedirectPC` at the next edge.
- `RedirectPC` output 32 — `CondTakenE ? PCTargetE : PCPlus4E`.
- `FlushD` output 1 — flush the IF/ID register.
- `FlushE` output 1 — flush the ID/EX register.
- `BranchCount` output 32 — resolved branches since reset.
- `MispredCount` output 32 — mispredictions since reset.

## Operation
- Resolve qualifier: `ResolveE = BranchE & ~StallE & (state == IDLE)`.
- Mispredict: `MispredE = ResolveE & (CondTakenE != PredTakenE)`.
- `RedirectE = FlushD = FlushE = MispredE`. These outputs are combinational in the same cycle.
- `RedirectPC` is always driven by the mux above. It is only meaningful while `RedirectE = 1`.
- State machine, two states:
  - IDLE -> RECOVER when `MispredE = 1`.
  - RECOVER -> IDLE unconditionally after one cycle.
  - In RECOVER, `BranchE` is ignored: no resolve, no BHT update, no count. The EX slot holds wrong-path or bubble content.
  - `StallE` does not hold RECOVER; it lasts exactly one cycle.
- BHT update at the edge when `ResolveE = 1`, at entry `PCE[IW+1:2]`:
  - If `CondTakenE = 1`, increment the entry, saturating at `2'b11`.
  - If `CondTakenE = 0`, decrement the entry, saturating at `2'b00`.
  - The update happens whether or not the prediction was correct.
- Statistics:
  - `BranchCount` increments on `ResolveE`.
  - `MispredCount` increments on `MispredE`.
  - Both saturate at `32'hFFFF_FFFF` and do not wrap.
- Read/write collision: when `PCF` and `PCE` index the same entry in one cycle, `PredTakenF` returns the pre-update value (read-before-write). There is no bypass.
- Aliasing between PCs with equal index bits is permitted and not detected.

## Timing
- Reset values, while `rst` is asserted and asynchronously on assertion:
  - Every BHT entry = `2'b01` (weakly not-taken).
  - `BranchCount = 0`, `MispredCount = 0`, state = IDLE.
  - `RedirectE`, `FlushD`, `FlushE` = 0, since they are gated by state IDLE and inputs; the bench must hold `BranchE = 0` during reset.
  - `PredTakenF` = 0 for every PC.
- Prediction latency: 0 cycles. `PredTakenF` follows `PCF` combinationally.
- Resolution latency: 0 cycles. The redirect and flushes are valid in the same cycle `BranchE` is presented in EX, and fetch takes `RedirectPC` at the following edge.
- BHT and counter updates become visible 1 cycle after the resolving edge.
- Back-to-back branches in IDLE with correct predictions resolve every cycle without bubbles.
- A branch presented in the RECOVER cycle is dropped. Valid pipeline flushing guarantees it is wrong-path.
- Stall: with `StallE = 1` there are no outputs asserted, no updates and no counting. The same branch resolves once, in the first cycle `StallE = 0`.
- `rst` asserted mid-RECOVER or mid-stall returns the block to the reset state immediately. No pending update survives.

## Test plan
- Reset, then `PCF = 0x100` -> `PredTakenF = 0`, counters 0, no flush.
- Branch at `PCE = 0x100`, `PredTakenE = 0`, `CondTakenE = 1`, target `0x200` -> same cycle `RedirectE = FlushD = FlushE = 1`, `RedirectPC = 0x200`. Next cycle state RECOVER with `BranchE = 1` ignored, entry `0x100` = `2'b10`, `PredTakenF(0x100) = 1`, `BranchCount = 1`, `MispredCount = 1`.
- Three correct taken resolves on `0x100` -> entry saturates at `2'b11`, no redirect, `BranchCount` +3. Then one not-taken -> mispredict, `RedirectPC = PCPlus4E = 0x104`, entry = `2'b10`.
- `StallE = 1` for 3 cycles with a mispredicting branch in EX -> no redirect, no update during the stall. On the release cycle exactly one redirect occurs and `MispredCount` increments by 1.
- Same-cycle `PCF = PCE = 0x140` while updating from `01` to `10` -> `PredTakenF = 0` that cycle and 1 the next.
- Assert `rst` during RECOVER after several updates -> all outputs and counters return to reset values and every entry reads `2'b01`.

Source files
------------

// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute-side signal bundle between the pipeline and branch_predict_ctrl.
// The pipeline drives through the master modport and the controller uses the slave modport.
interface branch_predict_ctrl_if;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic        BranchE;
  logic        StallE;
  logic [31:0] PCE;
  logic        PredTakenE;
  logic        CondTakenE;
  logic [31:0] PCTargetE;
  logic [31:0] PCPlus4E;
  logic        RedirectE;
  logic [31:0] RedirectPC;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] BranchCount;
  logic [31:0] MispredCount;

  modport master (
    output PCF, BranchE, StallE, PCE, PredTakenE, CondTakenE, PCTargetE, PCPlus4E,
    input  PredTakenF, RedirectE, RedirectPC, FlushD, FlushE, BranchCount, MispredCount
  );

  modport slave (
    input  PCF, BranchE, StallE, PCE, PredTakenE, CondTakenE, PCTargetE, PCPlus4E,
    output PredTakenF, RedirectE, RedirectPC, FlushD, FlushE, BranchCount, MispredCount
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Bimodal BHT predictor with execute-stage resolution, redirect/flush generation,
// a one-cycle recovery state and saturating branch/mispredict statistics.
module branch_predict_ctrl #(
  parameter int BHT_ENTRIES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_ctrl_if.slave  bus
);
  localparam int IW = $clog2(BHT_ENTRIES);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  bht_q [BHT_ENTRIES];
  logic [1:0]  bht_d [BHT_ENTRIES];
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  logic [IW-1:0] rd_idx_s;
  logic [IW-1:0] upd_idx_s;
  logic          resolve_s;
  logic          mispred_s;
  logic          unused_s;

  assign rd_idx_s  = bus.PCF[IW+1:2];
  assign upd_idx_s = bus.PCE[IW+1:2];
  assign unused_s  = ^{bus.PCF[31:IW+2], bus.PCF[1:0], bus.PCE[31:IW+2], bus.PCE[1:0]};

  // A branch in the recovery cycle is wrong-path content and must not resolve.
  assign resolve_s = bus.BranchE & ~bus.StallE & (state_q == IDLE);
  assign mispred_s = resolve_s & (bus.CondTakenE != bus.PredTakenE);

  assign bus.PredTakenF   = bht_q[rd_idx_s][1];
  assign bus.RedirectE    = mispred_s;
  assign bus.FlushD       = mispred_s;
  assign bus.FlushE       = mispred_s;
  assign bus.RedirectPC   = bus.CondTakenE ? bus.PCTargetE : bus.PCPlus4E;
  assign bus.BranchCount  = branch_count_q;
  assign bus.MispredCount = mispred_count_q;

  // Next-state logic for the recovery FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mispred_s) begin
          state_d = RECOVER;
        end else begin
          state_d = IDLE;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating 2-bit counter update at the resolving entry; reads see the old value.
  always_comb begin
    bht_d = bht_q;
    if (resolve_s) begin
      if (bus.CondTakenE) begin
        if (bht_q[upd_idx_s] != 2'b11) begin
          bht_d[upd_idx_s] = bht_q[upd_idx_s] + 2'b01;
        end else begin
          bht_d[upd_idx_s] = 2'b11;
        end
      end else begin
        if (bht_q[upd_idx_s] != 2'b00) begin
          bht_d[upd_idx_s] = bht_q[upd_idx_s] - 2'b01;
        end else begin
          bht_d[upd_idx_s] = 2'b00;
        end
      end
    end else begin
      bht_d = bht_q;
    end
  end

  // Statistics counters hold at all-ones instead of wrapping.
  always_comb begin
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (resolve_s && (branch_count_q != 32'hFFFF_FFFF)) begin
      branch_count_d = branch_count_q + 32'd1;
    end else begin
      branch_count_d = branch_count_q;
    end
    if (mispred_s && (mispred_count_q != 32'hFFFF_FFFF)) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end else begin
      mispred_count_d = mispred_count_q;
    end
  end

  // State, BHT and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      branch_count_q  <= 32'd0;
      mispred_count_q <= 32'd0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      state_q         <= state_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
      bht_q           <= bht_d;
    end
  end
endmodule
